// File: rtl/latch_mon_pkg.sv
// Shared types for the D-latch monitor: FSM state encoding and violation codes.
package latch_mon_pkg;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_TRANSP  = 2'd2,
        ST_HOLD    = 2'd3
    } mon_state_t;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_Q    = 2'd1;
    localparam logic [1:0] ERR_QN   = 2'd2;
    localparam logic [1:0] ERR_BOTH = 2'd3;

    function automatic logic [1:0] err_code_of(input logic bad_q, input logic bad_qn);
        logic [1:0] code;
        code = ERR_NONE;
        if (bad_q && bad_qn) code = ERR_BOTH;
        else if (bad_q)      code = ERR_Q;
        else if (bad_qn)     code = ERR_QN;
        return code;
    endfunction

endpackage

// File: rtl/latch_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (inc && count != CNT_MAX)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/latch_monitor.sv
// Scoreboard for a level-sensitive D latch: samples enable/data/Q/Qn, tracks the
// expected stored value and reports violations with a one-cycle err pulse.
module latch_monitor
    import latch_mon_pkg::*;
#(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 8
) (
    input  logic             C,
    input  logic             Rn,
    input  logic             lat_C,
    input  logic             lat_D,
    input  logic             lat_Q,
    input  logic             lat_Qn,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] win_count,
    output logic             exp_valid,
    output logic             exp_q
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

    logic       c_p0, c_p1;
    logic       d_p0, d_p1;
    logic       q_p0, qn_p0;
    mon_state_t state;
    logic [3:0] settle_cnt;
    logic       hold_skip;
    logic       en_fall, en_rise, d_chg;
    logic       chk_en, chk_ref;
    logic       bad_q, bad_qn, viol, win_inc;

    // Sample stage: one register on every latch signal, plus previous copies for edges
    always_ff @(posedge C or negedge Rn) begin
        if (!Rn) begin
            c_p0 <= 1'b0;
            c_p1 <= 1'b0;
        end else begin
            c_p0 <= lat_C;
            c_p1 <= c_p0;
        end
    end

    always_ff @(posedge C) begin
        d_p0  <= lat_D;
        d_p1  <= d_p0;
        q_p0  <= lat_Q;
        qn_p0 <= lat_Qn;
    end

    assign en_fall = c_p1 & ~c_p0;
    assign en_rise = ~c_p1 & c_p0;
    assign d_chg   = d_p0 ^ d_p1;

    // On the falling-enable cycle the latch holds the data of the last high cycle
    always_comb begin
        chk_en  = 1'b0;
        chk_ref = exp_q;
        case (state)
            ST_TRANSP: begin
                chk_en  = en_fall | ~d_chg;
                chk_ref = en_fall ? d_p1 : d_p0;
            end
            ST_HOLD:   chk_en = ~en_rise & ~hold_skip;
            default:   chk_en = 1'b0;
        endcase
        bad_q   = chk_en & (q_p0 != chk_ref);
        bad_qn  = chk_en & (qn_p0 == q_p0);
        viol    = bad_q | bad_qn;
        win_inc = en_fall & ((state == ST_SETTLE) | (state == ST_TRANSP));
    end

    // Check stage: FSM, expected value and violation report
    always_ff @(posedge C or negedge Rn) begin
        if (!Rn) begin
            state      <= ST_UNKNOWN;
            settle_cnt <= 4'd0;
            hold_skip  <= 1'b0;
            exp_valid  <= 1'b0;
            exp_q      <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            err <= viol;
            if (viol)
                err_code <= err_code_of(bad_q, bad_qn);
            case (state)
                ST_UNKNOWN: begin
                    if (c_p0) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                ST_SETTLE: begin
                    if (en_fall) begin
                        state     <= ST_HOLD;
                        exp_q     <= d_p1;
                        exp_valid <= 1'b1;
                        hold_skip <= 1'b1;
                    end else if (d_chg) begin
                        settle_cnt <= SETTLE_LD;
                    end else if (settle_cnt == 4'd0) begin
                        state     <= ST_TRANSP;
                        exp_q     <= d_p0;
                        exp_valid <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                ST_TRANSP: begin
                    exp_valid <= 1'b1;
                    if (en_fall) begin
                        state     <= ST_HOLD;
                        exp_q     <= d_p1;
                        hold_skip <= 1'b0;
                    end else begin
                        exp_q <= d_p0;
                        if (d_chg) begin
                            state      <= ST_SETTLE;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                end
                ST_HOLD: begin
                    hold_skip <= 1'b0;
                    if (en_rise) begin
                        state      <= ST_SETTLE;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                default: state <= ST_UNKNOWN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
        .clk   (C),
        .rst_n (Rn),
        .inc   (viol),
        .clear (1'b0),
        .count (err_count)
    );

    sat_counter #(.CNT_W(CNT_W)) u_win_cnt (
        .clk   (C),
        .rst_n (Rn),
        .inc   (win_inc),
        .clear (1'b0),
        .count (win_count)
    );

endmodule

// File: tb/tb_latch_monitor.sv
// Directed bench for latch_monitor: drives a behavioural latch with injectable faults.
module tb_latch_monitor;

    logic       C = 1'b0;
    logic       Rn;
    logic       lat_C, lat_D, lat_Q, lat_Qn;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] err_count, win_count;
    logic       exp_valid, exp_q;

    logic qv = 1'b0;
    logic fault_follow = 1'b0;
    logic fault_qn = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    latch_monitor #(.SETTLE(2), .CNT_W(8)) dut (
        .C         (C),
        .Rn        (Rn),
        .lat_C     (lat_C),
        .lat_D     (lat_D),
        .lat_Q     (lat_Q),
        .lat_Qn    (lat_Qn),
        .err       (err),
        .err_code  (err_code),
        .err_count (err_count),
        .win_count (win_count),
        .exp_valid (exp_valid),
        .exp_q     (exp_q)
    );

    always #5 C = ~C;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Drive one cycle from a negedge; returns at the following negedge.
    task automatic cyc(input logic c, input logic d);
        lat_C = c;
        lat_D = d;
        if (c) qv = d;
        lat_Q  = fault_follow ? d : qv;
        lat_Qn = fault_qn ? lat_Q : ~lat_Q;
        @(posedge C);
        @(negedge C);
    endtask

    task automatic do_reset();
        Rn = 1'b0;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        Rn = 1'b1;
    endtask

    initial begin
        Rn = 1'b0;
        lat_C = 1'b0; lat_D = 1'b0; lat_Q = 1'b0; lat_Qn = 1'b1;
        @(negedge C);
        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
        check_eq("rst_err",       err, 0);
        check_eq("rst_code",      err_code, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_win_count", win_count, 0);
        check_eq("rst_exp_valid", exp_valid, 0);
        check_eq("rst_exp_q",     exp_q, 0);

        // correct latch, D=1 window then D toggles in hold
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1);
        check_eq("transp_exp_q", exp_q, 1);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check_eq("hold_exp_q",     exp_q, 1);
        check_eq("hold_exp_valid", exp_valid, 1);
        check_eq("win1",           win_count, 1);
        check_eq("good_err_count", err_count, 0);
        check_eq("good_err",       err, 0);

        // Q wrongly follows D in hold: D 1->0
        fault_follow = 1'b1;
        cyc(1'b0, 1'b0);
        check_eq("follow_lat1", err, 0);
        cyc(1'b0, 1'b0);
        check_eq("follow_err",  err, 1);
        check_eq("follow_code", err_code, 1);
        check_eq("follow_cnt1", err_count, 1);
        cyc(1'b0, 1'b0);
        check_eq("follow_cnt2", err_count, 2);
        fault_follow = 1'b0;
        cyc(1'b0, 1'b1);
        check_eq("follow_tail", err, 1);
        cyc(1'b0, 1'b1);
        check_eq("follow_end_err",  err, 0);
        check_eq("follow_end_cnt",  err_count, 3);
        check_eq("follow_end_code", err_code, 1);

        // Qn forced equal to Q for 3 hold cycles
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1);
        fault_qn = 1'b1;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check_eq("qn_err",  err, 1);
        check_eq("qn_code", err_code, 2);
        cyc(1'b0, 1'b1);
        fault_qn = 1'b0;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        check_eq("qn_cnt",      err_count, 3);
        check_eq("qn_end_err",  err, 0);
        check_eq("qn_end_code", err_code, 2);

        // D rises in the same cycle enable falls: captured value is the old D
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        check_eq("cap_exp_q", exp_q, 0);
        check_eq("cap_cnt",   err_count, 3);
        check_eq("cap_win",   win_count, 2);

        // win_count saturation
        for (int i = 0; i < 300; i++) begin
            cyc(1'b1, 1'b0);
            cyc(1'b1, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
        end
        check_eq("win_sat",     win_count, 255);
        check_eq("sat_err_cnt", err_count, 3);

        // async reset mid-window
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1);
        check_eq("pre_rst_exp_q", exp_q, 1);
        #2 Rn = 1'b0;
        #1;
        check_eq("arst_err",       err, 0);
        check_eq("arst_code",      err_code, 0);
        check_eq("arst_err_count", err_count, 0);
        check_eq("arst_win_count", win_count, 0);
        check_eq("arst_exp_valid", exp_valid, 0);
        check_eq("arst_exp_q",     exp_q, 0);
        @(negedge C);
        cyc(1'b0, 1'b1);
        Rn = 1'b1;

        // no checks until a new transparent window
        fault_qn = 1'b1;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1);
        check_eq("post_rst_cnt",   err_count, 0);
        check_eq("post_rst_valid", exp_valid, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/latch_monitor.md
# latch_monitor

Synchronous checker that observes a level-sensitive D latch (enable, data, Q, Qn) and flags any departure from latch behaviour. It is the reader side of the latch interface: the bench or top level drives the latch, and this block samples all four signals on its own clock, tracks the expected stored value and counts violations. It sits beside any latch instance in the sequential-circuits labs as a self-checking scoreboard.

## Interface
- SETTLE, default 2: cycles after any change of enable or data (while enabled) during which Q/Qn are not checked; legal range 1..15.
- CNT_W, default 8: width of both counters.
- C  input  1  monitor clock; all sampling on rising edge.
- Rn  input  1  reset, asynchronous, active-low.
- lat_C  input  1  observed latch enable.
- lat_D  input  1  observed latch data.
- lat_Q  input  1  observed latch output.
- lat_Qn  input  1  observed latch complement output.
- err  output  1  one-cycle pulse per detected violation.
- err_code  output  2  cause of the last violation: 0 none, 1 Q≠expected, 2 Qn≠~Q, 3 both.
- err_count  output  CNT_W  saturating count of violation cycles.
- win_count  output  CNT_W  saturating count of completed transparent windows (enable 1→0).
- exp_valid  output  1  expected value is known.
- exp_q  output  1  current expected Q.

## Operation
- All four lat_* inputs are registered once (sample stage); all checks use the registered copies and the previous-cycle copies for edge detection.
- FSM states: UNKNOWN, SETTLE, TRANSP, HOLD.
- UNKNOWN: entered on reset; no checks; exp_valid=0. Sampled enable=1 → SETTLE.
- SETTLE: settle counter loads SETTLE-1 on entry and decrements each cycle; no checks. Counter reaching 0 with enable=1 → TRANSP. Enable dropping → HOLD (capture rule below). A data change while in SETTLE reloads the counter.
- TRANSP: exp_q follows sampled data each cycle; exp_valid=1. Check Q==data and Qn==~Q. Data change → SETTLE (reload). Enable 1→0 → HOLD.
- HOLD: exp_q frozen; check Q==exp_q and Qn==~Q every cycle. Enable 0→1 → SETTLE.
- Capture rule: on the enable 1→0 edge, exp_q takes the data value sampled in the last cycle enable was high, even if data changes in the same cycle enable falls. exp_valid becomes 1 at that point, also when leaving SETTLE directly.
- win_count increments on every enable 1→0 edge observed from SETTLE or TRANSP; never from UNKNOWN.
- Checks are disabled in UNKNOWN and SETTLE, and in the first HOLD cycle when entered from SETTLE.
- Violation: err=1 for one cycle, err_code updated, err_count+1. Persistent mismatch pulses err every cycle. err_code holds its value until the next violation.
- Counters saturate at 2^CNT_W−1, no wrap.

## Timing
- Reset values: err=0, err_code=0, err_count=0, win_count=0, exp_valid=0, exp_q=0, FSM=UNKNOWN, settle counter=0.
- Latency: a latch-side mismatch present at rising edge N (sampled) appears as err=1 after edge N+1 (sample register plus check register).
- Reset mid-operation clears everything immediately (async); the first post-reset check needs a new transparent window.
- Enable edge and data change in the same sample: enable edge has priority over the data-change rule.

## Structure
- Package latch_mon_pkg: state encoding (UNKNOWN=0, SETTLE=1, TRANSP=2, HOLD=3) and err_code constants.
- Sub-module sat_counter (parameter CNT_W, inputs inc, clear, output count), instantiated twice for err_count and win_count.

## Test plan
- Reset with enable=0 for 10 cycles → no err, exp_valid=0, counts 0.
- Correct latch: D=1, enable high 10 cycles then low, D toggles in hold → exp_q=1, win_count=1, err_count=0.
- Faulty latch with Q following D while enable=0 (D 1→0 in hold) → err pulses start 2 cycles after the D change, err_code=1, err_count increments each cycle.
- Forced Qn=Q for 3 cycles in HOLD → 3 err pulses, err_code=2, err_count=3.
- D 0→1 in the same cycle enable falls, previous D=0 → exp_q=0, no err when Q stays 0.
- 300 enable windows with CNT_W=8 → win_count saturates at 255. Assert Rn low mid-window → all outputs return to reset values at once.
